multicycle_ctrl: RTL

MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

---
 rtl/multicycle_ctrl_if.sv | 28 ++
 rtl/multicycle_ctrl.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_ctrl_if.sv
// Memory-side bus of the multicycle controller: instruction fetch handshake
// plus data read/write request strobes.
interface multicycle_ctrl_if;
  // Handshake: in IF, instr is taken on the first cycle imem_ready=1.
  // In MEM, MemRead/MemWrite is the request; it stays high every cycle
  // until the first cycle dmem_ready=1, which completes the access.
  logic [31:0] instr;
  logic        imem_ready;
  logic        dmem_ready;
  logic        MemRead;
  logic        MemWrite;

  modport master (
    input  instr,
    input  imem_ready,
    input  dmem_ready,
    output MemRead,
    output MemWrite
  );

  modport slave (
    output instr,
    output imem_ready,
    output dmem_ready,
    input  MemRead,
    input  MemWrite
  );
endinterface

// File: rtl/multicycle_ctrl.sv
// Multicycle RV32 subset controller (IF/ID/EX/MEM/WB/TRAP) with registered outputs.
// Optional performance counters are built when MC_PERF_CNT_EN is defined.
module multicycle_ctrl #(
  parameter int MEM_TIMEOUT = 15,
  parameter int CNT_WIDTH   = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  multicycle_ctrl_if.master    mem,
  input  logic                 Zero,
  input  logic                 Lt,
  output logic                 ALUSrc,
  output logic                 RegWrite,
  output logic                 MemToReg,
  output logic                 loadPC,
  output logic [3:0]           ALUCtrl,
  output logic [1:0]           PCSrc,
  output logic [2:0]           state,
  output logic                 illegal
`ifdef MC_PERF_CNT_EN
  ,
  output logic [CNT_WIDTH-1:0] cycle_cnt,
  output logic [CNT_WIDTH-1:0] instret_cnt
`endif
);

  typedef enum logic [2:0] {
    S_IF   = 3'd0,
    S_ID   = 3'd1,
    S_EX   = 3'd2,
    S_MEM  = 3'd3,
    S_WB   = 3'd4,
    S_TRAP = 3'd5
  } state_e;

  localparam logic [3:0] ALU_AND  = 4'b0000;
  localparam logic [3:0] ALU_OR   = 4'b0001;
  localparam logic [3:0] ALU_ADD  = 4'b0010;
  localparam logic [3:0] ALU_SUB  = 4'b0110;
  localparam logic [3:0] ALU_SLT  = 4'b0111;
  localparam logic [3:0] ALU_SRL  = 4'b1000;
  localparam logic [3:0] ALU_SLL  = 4'b1001;
  localparam logic [3:0] ALU_SRA  = 4'b1010;
  localparam logic [3:0] ALU_XOR  = 4'b1101;
  localparam logic [3:0] ALU_PASS = 4'b1111;

  localparam int WAIT_W = (MEM_TIMEOUT > 2) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'((MEM_TIMEOUT > 0) ? MEM_TIMEOUT - 1 : 0);

  typedef struct packed {
    logic       legal;
    logic       alu_src;
    logic [3:0] alu_ctrl;
    logic       is_load;
    logic       is_store;
    logic       is_branch;
    logic       is_jal;
    logic       reg_write;
  } dec_t;

  // Illegal encodings decode to all-zero so they drive nothing on the way to TRAP.
  function automatic dec_t decode(input logic [31:0] ir);
    dec_t       d;
    logic [6:0] op;
    logic [2:0] f3;
    logic [6:0] f7;
    op = ir[6:0];
    f3 = ir[14:12];
    f7 = ir[31:25];
    d  = '0;
    case (op)
      7'b0110011: begin
        d.legal     = 1'b1;
        d.reg_write = 1'b1;
        if (f7 == 7'b0000000) begin
          case (f3)
            3'b000:  d.alu_ctrl = ALU_ADD;
            3'b001:  d.alu_ctrl = ALU_SLL;
            3'b010:  d.alu_ctrl = ALU_SLT;
            3'b100:  d.alu_ctrl = ALU_XOR;
            3'b101:  d.alu_ctrl = ALU_SRL;
            3'b110:  d.alu_ctrl = ALU_OR;
            3'b111:  d.alu_ctrl = ALU_AND;
            default: d.legal    = 1'b0;
          endcase
        end else if (f7 == 7'b0100000) begin
          case (f3)
            3'b000:  d.alu_ctrl = ALU_SUB;
            3'b101:  d.alu_ctrl = ALU_SRA;
            default: d.legal    = 1'b0;
          endcase
        end else begin
          d.legal = 1'b0;
        end
      end
      7'b0010011: begin
        d.legal     = 1'b1;
        d.alu_src   = 1'b1;
        d.reg_write = 1'b1;
        case (f3)
          3'b000: d.alu_ctrl = ALU_ADD;
          3'b010: d.alu_ctrl = ALU_SLT;
          3'b100: d.alu_ctrl = ALU_XOR;
          3'b110: d.alu_ctrl = ALU_OR;
          3'b111: d.alu_ctrl = ALU_AND;
          3'b001: begin
            d.alu_ctrl = ALU_SLL;
            d.legal    = (f7 == 7'b0000000);
          end
          3'b101: begin
            if (f7 == 7'b0000000)      d.alu_ctrl = ALU_SRL;
            else if (f7 == 7'b0100000) d.alu_ctrl = ALU_SRA;
            else                       d.legal    = 1'b0;
          end
          default: d.legal = 1'b0;
        endcase
      end
      7'b0000011: begin
        d.legal     = 1'b1;
        d.alu_src   = 1'b1;
        d.alu_ctrl  = ALU_ADD;
        d.is_load   = 1'b1;
        d.reg_write = 1'b1;
      end
      7'b0100011: begin
        d.legal    = 1'b1;
        d.alu_src  = 1'b1;
        d.alu_ctrl = ALU_ADD;
        d.is_store = 1'b1;
      end
      7'b0110111: begin
        d.legal     = 1'b1;
        d.alu_src   = 1'b1;
        d.alu_ctrl  = ALU_PASS;
        d.reg_write = 1'b1;
      end
      7'b1101111: begin
        d.legal     = 1'b1;
        d.alu_ctrl  = ALU_ADD;
        d.is_jal    = 1'b1;
        d.reg_write = 1'b1;
      end
      7'b1100011: begin
        d.alu_ctrl  = ALU_SUB;
        d.is_branch = 1'b1;
        d.legal     = (f3 == 3'b000) || (f3 == 3'b001) || (f3 == 3'b100) || (f3 == 3'b101);
      end
      default: d.legal = 1'b0;
    endcase
    if (!d.legal) d = '0;
    return d;
  endfunction

  state_e            state_q, state_d;
  logic [31:0]       ir_q, ir_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic              alu_src_q, alu_src_d;
  logic [3:0]        alu_ctrl_q, alu_ctrl_d;
  logic              reg_write_q, reg_write_d;
  logic              mem_to_reg_q, mem_to_reg_d;
  logic              load_pc_q, load_pc_d;
  logic              mem_read_q, mem_read_d;
  logic              mem_write_q, mem_write_d;
  logic [1:0]        pc_src_q, pc_src_d;
  logic              illegal_q, illegal_d;
  dec_t              dec_q, dec_d;
  logic              taken;
  logic              in_dp;

  assign dec_q = decode(ir_q);

  always_comb begin
    case (ir_q[14:12])
      3'b000:  taken = Zero;
      3'b001:  taken = !Zero;
      3'b100:  taken = Lt;
      3'b101:  taken = !Lt;
      default: taken = 1'b0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    ir_d    = ir_q;
    wait_d  = wait_q;
    case (state_q)
      S_IF: begin
        if (mem.imem_ready) begin
          ir_d    = mem.instr;
          state_d = S_ID;
        end
      end
      S_ID: state_d = dec_q.legal ? S_EX : S_TRAP;
      S_EX: begin
        state_d = (dec_q.is_load || dec_q.is_store) ? S_MEM : S_WB;
        wait_d  = '0;
      end
      S_MEM: begin
        // Completion on the last allowed cycle takes priority over the timeout.
        if (mem.dmem_ready)                                     state_d = S_WB;
        else if ((MEM_TIMEOUT > 0) && (wait_q == WAIT_LAST))    state_d = S_TRAP;
        else                                                    wait_d  = wait_q + 1'b1;
      end
      S_WB:    state_d = S_IF;
      S_TRAP:  state_d = S_TRAP;
      default: state_d = S_IF;
    endcase

    // Outputs are computed for the state being entered so they can be registered.
    dec_d        = decode(ir_d);
    in_dp        = (state_d == S_ID) || (state_d == S_EX) || (state_d == S_MEM) || (state_d == S_WB);
    alu_src_d    = in_dp && dec_d.alu_src;
    alu_ctrl_d   = in_dp ? dec_d.alu_ctrl : 4'b0000;
    mem_read_d   = (state_d == S_MEM) && dec_d.is_load;
    mem_write_d  = (state_d == S_MEM) && dec_d.is_store;
    reg_write_d  = (state_d == S_WB) && dec_d.reg_write;
    mem_to_reg_d = (state_d == S_WB) && dec_d.is_load;
    load_pc_d    = (state_d == S_WB);
    pc_src_d     = 2'd0;
    if (state_d == S_WB) begin
      if (dec_d.is_jal)                pc_src_d = 2'd2;
      else if (dec_d.is_branch && taken) pc_src_d = 2'd1;
    end
    illegal_d    = (state_d == S_TRAP);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= S_IF;
      ir_q         <= '0;
      wait_q       <= '0;
      alu_src_q    <= 1'b0;
      alu_ctrl_q   <= 4'b0000;
      reg_write_q  <= 1'b0;
      mem_to_reg_q <= 1'b0;
      load_pc_q    <= 1'b0;
      mem_read_q   <= 1'b0;
      mem_write_q  <= 1'b0;
      pc_src_q     <= 2'd0;
      illegal_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      ir_q         <= ir_d;
      wait_q       <= wait_d;
      alu_src_q    <= alu_src_d;
      alu_ctrl_q   <= alu_ctrl_d;
      reg_write_q  <= reg_write_d;
      mem_to_reg_q <= mem_to_reg_d;
      load_pc_q    <= load_pc_d;
      mem_read_q   <= mem_read_d;
      mem_write_q  <= mem_write_d;
      pc_src_q     <= pc_src_d;
      illegal_q    <= illegal_d;
    end
  end

  assign state        = state_q;
  assign ALUSrc       = alu_src_q;
  assign ALUCtrl      = alu_ctrl_q;
  assign RegWrite     = reg_write_q;
  assign MemToReg     = mem_to_reg_q;
  assign loadPC       = load_pc_q;
  assign mem.MemRead  = mem_read_q;
  assign mem.MemWrite = mem_write_q;
  assign PCSrc        = pc_src_q;
  assign illegal      = illegal_q;

  logic unused_ir;
  assign unused_ir = ^{ir_q[31:15], ir_q[11:7]};

`ifdef MC_PERF_CNT_EN
  logic [CNT_WIDTH-1:0] cycle_q;
  logic [CNT_WIDTH-1:0] instret_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cycle_q   <= '0;
      instret_q <= '0;
    end else begin
      if (state_q != S_TRAP) cycle_q   <= cycle_q + 1'b1;
      if (state_q == S_WB)   instret_q <= instret_q + 1'b1;
    end
  end

  assign cycle_cnt   = cycle_q;
  assign instret_cnt = instret_q;
`endif

endmodule
